ahb_lite_mem_slave: RTL and testbench

AHB5-Lite subordinate (responder) backed by a word-organised register memory, with optional programmable wait states and a two-cycle ERROR response. It sits behind the AHB decoder/multiplexor as the far end of the `ahb_if` bus. It is the default DUT-side responder for agent bring-up and the building block for on-chip scratch RAM.

---
 rtl/ahb_lite_mem_slave.sv | 175 +++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_slave.sv
// ============================================================================
// Module   : ahb_lite_mem_slave
// Brief    : AHB5-Lite subordinate backed by a word-organised register memory
//            with a two-cycle ERROR response. Define AHB_SLV_WAIT_EN to build
//            the programmable wait-state counter (WAIT_STATES per OKAY phase).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_mem_slave #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int c_aw = $clog2(DEPTH_WORDS);
    localparam int c_bw = c_aw + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [c_aw-1:0] idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;
    logic            valid_q, valid_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            w_ready;
    logic            w_take;
    logic            w_err;
    logic            w_we;
    logic [3:0]      w_lanes;
    logic            w_unused;

`ifdef AHB_SLV_WAIT_EN
    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES - 1);
    logic [3:0]      wcnt_q, wcnt_d;
`endif

    // A new address phase can only be taken while our own data phase is not stalling.
    assign w_ready = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign w_take  = hsel & hreadyin & htrans[1] & w_ready;
    assign w_err   = (hsize > 3'b010)
                   | ((hsize == 3'b001) & haddr[0])
                   | ((hsize == 3'b010) & (|haddr[1:0]))
                   | (|haddr[31:c_bw]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        valid_d = valid_q;
`ifdef AHB_SLV_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        if (w_ready) begin
            valid_d = w_take & ~w_err;
            if (w_take) begin
                idx_d   = haddr[c_bw-1:2];
                off_d   = haddr[1:0];
                size_d  = hsize;
                write_d = hwrite;
            end
            if (!w_take) begin
                state_d = S_IDLE;
            end else if (w_err) begin
                state_d = S_ERR1;
`ifdef AHB_SLV_WAIT_EN
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                wcnt_d  = c_wait_load;
`endif
            end else begin
                state_d = S_DATA;
            end
        end else begin
            case (state_q)
                S_ERR1: state_d = S_ERR2;
`ifdef AHB_SLV_WAIT_EN
                S_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        state_d = S_DATA;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= 3'b000;
            write_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
            wcnt_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
            valid_q <= valid_d;
`ifdef AHB_SLV_WAIT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        w_lanes = 4'b0000;
        case (size_q)
            3'b000:  w_lanes[off_q] = 1'b1;
            3'b001:  w_lanes = off_q[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // Gated by hresetn so a write in flight when reset arrives is dropped.
    assign w_we = hresetn & (state_q == S_DATA) & valid_q & write_q;

    always_ff @(posedge hclk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout = w_ready;
    assign hresp     = {1'b0, (state_q == S_ERR1) || (state_q == S_ERR2)};
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'h0;

`ifdef AHB_SLV_WAIT_EN
    assign w_unused = ^{hburst, hprot, htrans[0]};
`else
    assign w_unused = ^{hburst, hprot, htrans[0], (WAIT_STATES != 0)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
// Testbench for ahb_lite_mem_slave: randomized AHB traffic against a word-array
// reference model, with a queue-based scoreboard checked by a bus monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_lite_mem_slave;

    localparam int DEPTH = 256;
    localparam int WS    = 3;
`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WS = WS;
`else
    localparam int EXP_WS = 0;
`endif

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    always #5 clk = ~clk;
    assign hreadyin = hreadyout;

    ahb_lite_mem_slave #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .hclk      (clk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hreadyin  (hreadyin),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] nxt_wdata = 32'h0;
    logic [31:0] last_rdata = 32'h0;

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00)
               || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic bit lane_on(input int b, input logic [1:0] off, input logic [2:0] s);
        if (s == 3'd0) return b == int'(off);
        if (s == 3'd1) return (b / 2) == int'(off[1]);
        return 1'b1;
    endfunction

    // One address-phase cycle, held until the bus is ready; returns at posedge+1.
    task automatic drive_cycle(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                               input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                               input bit upd);
        exp_t e;
        int   guard;
        logic [7:0] idx;
        hwdata = nxt_wdata;
        hsel   = sel;
        htrans = tr;
        haddr  = addr;
        hwrite = wr;
        hsize  = sz;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        if (sel && tr[1]) begin
            idx     = addr[9:2];
            e.err   = model_err(addr, sz);
            e.rd    = !wr;
            e.waits = e.err ? 1 : EXP_WS;
            e.data  = (!wr && !e.err) ? model[idx] : 32'h0;
            if (!e.err && wr && upd) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_on(b, addr[1:0], sz)) model[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            q.push_back(e);
        end
        guard = 0;
        @(negedge clk);
        while (!hreadyout && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: hreadyout stuck at %b, required 1", hreadyout);
        end
        @(posedge clk);
        #1;
        nxt_wdata = (sel && tr[1] && wr) ? wd : 32'h0;
    endtask

    task automatic wr_t(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d);
        drive_cycle(1'b1, tr, a, 1'b1, s, d, 1'b1);
    endtask

    task automatic rd_t(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] s);
        drive_cycle(1'b1, tr, a, 1'b0, s, 32'h0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pairs each completed data phase with the oldest expected response.
    logic       pending    = 1'b0;
    int         stall      = 0;
    logic [1:0] first_resp = 2'b00;
    logic       prev_rstn  = 1'b1;
    exp_t       me;

    always @(negedge clk) begin
        if (!prev_rstn) begin
            n_tests++;
            if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state: ready=%b resp=%b rdata=%h, required 1/00/0",
                         hreadyout, hresp, hrdata);
            end
        end else if (hresetn && pending) begin
            if (!hreadyout) begin
                stall++;
                if (stall == 1) first_resp = hresp;
            end else begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_response: resp=%b rdata=%h, required no transfer",
                             hresp, hrdata);
                end else begin
                    me = q.pop_front();
                    if (hresp !== (me.err ? 2'b01 : 2'b00) || stall != me.waits ||
                        (me.err && first_resp !== 2'b01) || hrdata !== me.data) begin
                        n_fail++;
                        $display("FAIL data_phase: resp=%b waits=%0d first=%b rdata=%h, required resp=%b waits=%0d rdata=%h",
                                 hresp, stall, first_resp, hrdata, me.err ? 2'b01 : 2'b00,
                                 me.waits, me.data);
                    end
                    if (me.rd && !me.err) last_rdata = hrdata;
                end
            end
        end else if (hresetn) begin
            n_tests++;
            if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_phase: ready=%b resp=%b rdata=%h, required 1/00/0",
                         hreadyout, hresp, hrdata);
            end
        end
        if (!hresetn) begin
            q.delete();
            pending = 1'b0;
        end else if (hreadyout) begin
            pending = hsel && htrans[1];
            stall   = 0;
        end
        prev_rstn = hresetn;
    end

    logic [31:0] ra, rw;
    logic [2:0]  rs;

    initial begin
        hresetn = 1'b0;
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
        repeat (3) begin
            hsel   = 1'($urandom);
            htrans = 2'($urandom);
            haddr  = 32'($urandom_range(0, 1023));
            hwrite = 1'($urandom);
            hsize  = 3'($urandom_range(0, 2));
            hwdata = $urandom;
            @(posedge clk);
            #1;
        end
        hresetn = 1'b1;
        hsel = 1'b0;
        htrans = 2'b00;

        for (int i = 0; i < DEPTH; i++) wr_t(2'b10, 32'(i * 4), 3'd2, $urandom);

        wr_t(2'b10, 32'h10, 3'd2, 32'hDEADBEEF);
        rd_t(2'b10, 32'h10, 3'd2);
        idle(6);
        check32("word_readback", last_rdata, 32'hDEADBEEF);

        wr_t(2'b10, 32'h20, 3'd2, 32'h00000000);
        wr_t(2'b10, 32'h23, 3'd0, 32'hAB000000);
        wr_t(2'b10, 32'h20, 3'd1, 32'h00001234);
        rd_t(2'b10, 32'h20, 3'd2);
        idle(6);
        check32("byte_half_lanes", last_rdata, 32'hAB001234);

        rd_t(2'b10, 32'h400, 3'd2);
        wr_t(2'b10, 32'h22, 3'd2, 32'hFFFFFFFF);
        rd_t(2'b10, 32'h20, 3'd2);
        rd_t(2'b10, 32'h10, 3'd3);
        idle(6);
        check32("error_no_write", last_rdata, 32'hAB001234);

        wr_t(2'b10, 32'h40, 3'd2, $urandom);
        wr_t(2'b11, 32'h44, 3'd2, $urandom);
        wr_t(2'b11, 32'h48, 3'd2, $urandom);
        wr_t(2'b11, 32'h4C, 3'd2, 32'hC0FFEE4C);
        rd_t(2'b10, 32'h40, 3'd2);
        rd_t(2'b01, 32'h44, 3'd2);
        rd_t(2'b11, 32'h44, 3'd2);
        rd_t(2'b01, 32'h48, 3'd2);
        rd_t(2'b11, 32'h48, 3'd2);
        rd_t(2'b11, 32'h4C, 3'd2);
        idle(6);
        check32("burst_last_beat", last_rdata, 32'hC0FFEE4C);

        wr_t(2'b10, 32'h80, 3'd2, 32'h5A5A0080);
        drive_cycle(1'b1, 2'b11, 32'h84, 1'b1, 3'd2, 32'h99990084, 1'b0);
        hwdata  = 32'h99990084;
        hsel    = 1'b0;
        htrans  = 2'b00;
        hresetn = 1'b0;
        @(posedge clk);
        #1;
        hresetn   = 1'b1;
        nxt_wdata = 32'h0;
        rd_t(2'b10, 32'h84, 3'd2);
        rd_t(2'b10, 32'h80, 3'd2);
        idle(6);
        check32("pre_reset_write_kept", last_rdata, 32'h5A5A0080);

        for (int i = 0; i < 300; i++) begin
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ra = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) begin
                if (rs == 3'd1) ra[0] = 1'b0;
                if (rs == 3'd2) ra[1:0] = 2'b00;
            end
            rw = $urandom;
            drive_cycle(1'($urandom_range(0, 9) != 0), 2'($urandom), ra, 1'($urandom), rs, rw, 1'b1);
        end
        idle(8);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
